// File: rtl/alu_mdu.sv
// Registered ALU with an iterative shift-add multiplier / restoring divider.
// Operands and results move on independent valid/ready handshakes.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  input  logic [1:0]       MulDiv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_hi,
  output logic             V,
  output logic             div0
);

  localparam int unsigned CW = SHW + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, b_mag, a_raw;
  logic             neg_q, neg_r, div0_p, ovf_p;

  logic accept, md_op, is_mul, is_div;

  assign is_mul   = (MulDiv == 2'b01);
  assign is_div   = (MulDiv == 2'b10);
  assign md_op    = is_mul || is_div;
  assign in_ready = reset && (state_q == S_IDLE) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ALU datapath
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_op, alu_z;
  logic [SHW-1:0]   shamt;
  logic             alu_v, eq, lt, a_zero, a_neg, cmp;

  assign b_op   = ALUFun[0] ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, b_op} + (WIDTH+1)'(ALUFun[0]);
  assign shamt  = A[SHW-1:0];
  assign eq     = (A == B);
  assign lt     = Sign ? ($signed(A) < $signed(B)) : (A < B);
  assign a_zero = (A == '0);
  assign a_neg  = Sign && A[WIDTH-1];

  always_comb begin
    cmp = 1'b0;
    case (ALUFun[3:1])
      3'b001:  cmp = eq;
      3'b000:  cmp = !eq;
      3'b010:  cmp = lt;
      3'b110:  cmp = a_neg || a_zero;
      3'b101:  cmp = a_neg;
      3'b111:  cmp = !a_neg && !a_zero;
      default: cmp = 1'b0;
    endcase
  end

  always_comb begin
    alu_z = '0;
    alu_v = 1'b0;
    case (ALUFun[5:4])
      2'b00: begin
        alu_z = sum[WIDTH-1:0];
        if (Sign)
          alu_v = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        else
          alu_v = ALUFun[0] ? !sum[WIDTH] : sum[WIDTH];
      end
      2'b01: begin
        case (ALUFun[3:0])
          4'b0001: alu_z = ~(A | B);
          4'b1110: alu_z = A | B;
          4'b1000: alu_z = A & B;
          4'b0110: alu_z = A ^ B;
          default: alu_z = A;
        endcase
      end
      2'b10: begin
        case (ALUFun[1:0])
          2'b00:   alu_z = B << shamt;
          2'b01:   alu_z = B >> shamt;
          2'b11:   alu_z = WIDTH'($signed(B) >>> shamt);
          default: alu_z = '0;
        endcase
      end
      default: alu_z = {{(WIDTH-1){1'b0}}, cmp};
    endcase
  end

  // Operand magnitudes and iteration step logic
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag_in, div_rem;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [2*WIDTH-1:0] prod_neg;
  logic             div_ge;

  assign a_sgn    = Sign && A[WIDTH-1];
  assign b_sgn    = Sign && B[WIDTH-1];
  assign a_mag    = a_sgn ? -A : A;
  assign b_mag_in = b_sgn ? -B : B;
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
  assign div_sh   = {hi, lo[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_mag});
  assign div_rem  = div_sh[WIDTH-1:0] - b_mag;
  assign prod_neg = -{hi, lo};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept && md_op) state_d = is_mul ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (cnt == CW'(WIDTH)) state_d = S_FIX;
      S_FIX:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Engine registers: WIDTH iteration edges, then one in-place sign fix-up edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      b_mag  <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_p <= 1'b0;
      ovf_p  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && md_op) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= a_mag;
            b_mag  <= b_mag_in;
            a_raw  <= A;
            neg_q  <= a_sgn ^ b_sgn;
            neg_r  <= a_sgn;
            div0_p <= is_div && (B == '0);
            ovf_p  <= is_div && Sign && (A == MIN_VAL) && (B == '1);
          end
        end
        S_MUL: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH)) begin
            if (neg_q) {hi, lo} <= prod_neg;
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
        end
        S_DIV: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH)) begin
            if (neg_q) lo <= -lo;
            if (neg_r) hi <= -hi;
          end else begin
            hi <= div_ge ? div_rem : div_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Z         <= '0;
      Z_hi      <= '0;
      V         <= 1'b0;
      div0      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !md_op) begin
      out_valid <= 1'b1;
      Z         <= alu_z;
      Z_hi      <= '0;
      V         <= alu_v;
      div0      <= 1'b0;
    end else if (state_q == S_FIX) begin
      out_valid <= 1'b1;
      Z         <= div0_p ? '1 : lo;
      Z_hi      <= div0_p ? a_raw : hi;
      V         <= ovf_p;
      div0      <= div0_p;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
